// File: rtl/decode_execute_reg_if.sv
// Decode-to-execute bundle: decoded instruction in, registered execute copy,
// stall and forwarding selects out.
interface decode_execute_reg_if #(
  parameter int XLEN  = 32,
  parameter int REGW  = 5,
  parameter int CTRLW = 8,
  parameter int CNTW  = 16
);
  logic             valid_d;
  logic [XLEN-1:0]  pc_d;
  logic [REGW-1:0]  rs1_d;
  logic [REGW-1:0]  rs2_d;
  logic [REGW-1:0]  rd_d;
  logic [XLEN-1:0]  rd1_d;
  logic [XLEN-1:0]  rd2_d;
  logic [XLEN-1:0]  imm_d;
  logic [CTRLW-1:0] ctrl_d;
  logic             reg_write_d;
  logic             mem_read_d;
  logic             flush_e;
  logic             hold_e;
  logic [REGW-1:0]  rd_m;
  logic             reg_write_m;
  logic [REGW-1:0]  rd_w;
  logic             reg_write_w;

  logic             valid_e;
  logic [XLEN-1:0]  pc_e;
  logic [REGW-1:0]  rs1_e;
  logic [REGW-1:0]  rs2_e;
  logic [REGW-1:0]  rd_e;
  logic [XLEN-1:0]  rd1_e;
  logic [XLEN-1:0]  rd2_e;
  logic [XLEN-1:0]  imm_e;
  logic [CTRLW-1:0] ctrl_e;
  logic             reg_write_e;
  logic             mem_read_e;
  logic             stall_d;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNTW-1:0]  bubble_cnt;

  modport master (
    output valid_d, pc_d, rs1_d, rs2_d, rd_d, rd1_d, rd2_d, imm_d, ctrl_d,
           reg_write_d, mem_read_d, flush_e, hold_e, rd_m, reg_write_m,
           rd_w, reg_write_w,
    input  valid_e, pc_e, rs1_e, rs2_e, rd_e, rd1_e, rd2_e, imm_e, ctrl_e,
           reg_write_e, mem_read_e, stall_d, fwd_a, fwd_b, bubble_cnt
  );

  modport slave (
    input  valid_d, pc_d, rs1_d, rs2_d, rd_d, rd1_d, rd2_d, imm_d, ctrl_d,
           reg_write_d, mem_read_d, flush_e, hold_e, rd_m, reg_write_m,
           rd_w, reg_write_w,
    output valid_e, pc_e, rs1_e, rs2_e, rd_e, rd1_e, rd2_e, imm_e, ctrl_e,
           reg_write_e, mem_read_e, stall_d, fwd_a, fwd_b, bubble_cnt
  );
endinterface

// File: rtl/decode_execute_reg.sv
// Decode/execute pipeline register with load-use bubble insertion, flush,
// hold, forwarding selects and a saturating bubble counter.
module decode_execute_reg #(
  parameter int XLEN  = 32,
  parameter int REGW  = 5,
  parameter int CTRLW = 8,
  parameter int CNTW  = 16
) (
  input logic                clk,
  input logic                rst,
  decode_execute_reg_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [REGW-1:0]  rs1;
    logic [REGW-1:0]  rs2;
    logic [REGW-1:0]  rd;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  imm;
    logic [CTRLW-1:0] ctrl;
    logic             reg_write;
    logic             mem_read;
  } stage_t;

  stage_t          stage_q, stage_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            lu_s;

  // Youngest producer (memory stage) beats writeback.
  function automatic logic [1:0] fwd_sel(
    input logic            valid,
    input logic [REGW-1:0] rs,
    input logic [REGW-1:0] rd_m,
    input logic            wr_m,
    input logic [REGW-1:0] rd_w,
    input logic            wr_w
  );
    logic [1:0] sel;
    if (valid && wr_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (valid && wr_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign lu_s = stage_q.valid & stage_q.mem_read & (stage_q.rd != '0) &
                bus.valid_d &
                ((stage_q.rd == bus.rs1_d) | (stage_q.rd == bus.rs2_d));

  // Next-state selection: flush, then hold, then load-use bubble, then capture.
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (bus.flush_e) begin
      stage_d = '0;
    end else if (bus.hold_e) begin
      stage_d = stage_q;
    end else if (lu_s) begin
      stage_d = '0;
      if (&cnt_q) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end else begin
      stage_d.valid     = bus.valid_d;
      stage_d.pc        = bus.pc_d;
      stage_d.rs1       = bus.rs1_d;
      stage_d.rs2       = bus.rs2_d;
      stage_d.rd        = bus.rd_d;
      stage_d.rd1       = bus.rd1_d;
      stage_d.rd2       = bus.rd2_d;
      stage_d.imm       = bus.imm_d;
      stage_d.ctrl      = bus.ctrl_d;
      stage_d.reg_write = bus.valid_d & bus.reg_write_d;
      stage_d.mem_read  = bus.valid_d & bus.mem_read_d;
    end
  end

  // Execute-stage state and bubble counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.valid_e     = stage_q.valid;
  assign bus.pc_e        = stage_q.pc;
  assign bus.rs1_e       = stage_q.rs1;
  assign bus.rs2_e       = stage_q.rs2;
  assign bus.rd_e        = stage_q.rd;
  assign bus.rd1_e       = stage_q.rd1;
  assign bus.rd2_e       = stage_q.rd2;
  assign bus.imm_e       = stage_q.imm;
  assign bus.ctrl_e      = stage_q.ctrl;
  assign bus.reg_write_e = stage_q.reg_write;
  assign bus.mem_read_e  = stage_q.mem_read;
  assign bus.bubble_cnt  = cnt_q;

  assign bus.stall_d = ~bus.flush_e & (bus.hold_e | lu_s);
  assign bus.fwd_a   = fwd_sel(stage_q.valid, stage_q.rs1, bus.rd_m,
                               bus.reg_write_m, bus.rd_w, bus.reg_write_w);
  assign bus.fwd_b   = fwd_sel(stage_q.valid, stage_q.rs2, bus.rd_m,
                               bus.reg_write_m, bus.rd_w, bus.reg_write_w);

endmodule

// File: tb/tb_decode_execute_reg.sv
// Randomized and directed bench for decode_execute_reg against a
// cycle-level behavioural model of the execute slot.
module tb_decode_execute_reg;
  localparam int XLEN  = 32;
  localparam int REGW  = 5;
  localparam int CTRLW = 8;
  localparam int CNTW  = 4;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  decode_execute_reg_if #(.XLEN(XLEN), .REGW(REGW), .CTRLW(CTRLW), .CNTW(CNTW)) bus ();

  decode_execute_reg #(.XLEN(XLEN), .REGW(REGW), .CTRLW(CTRLW), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model of what execute should hold: one instruction record plus a count.
  typedef struct {
    bit        valid;
    bit [31:0] pc, rd1, rd2, imm;
    bit [4:0]  rs1, rs2, rd;
    bit [7:0]  ctrl;
    bit        wr, ld;
  } instr_t;

  instr_t m_e;
  int     m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b.valid = 0; b.pc = 0; b.rd1 = 0; b.rd2 = 0; b.imm = 0;
    b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.ctrl = 0; b.wr = 0; b.ld = 0;
    return b;
  endfunction

  function automatic bit load_use();
    bit dep;
    dep = (m_e.rd == bus.rs1_d) || (m_e.rd == bus.rs2_d);
    return m_e.valid && m_e.ld && (m_e.rd != 0) && bus.valid_d && dep;
  endfunction

  function automatic bit [1:0] want_fwd(input bit [4:0] rs);
    if (!m_e.valid) return 2'd0;
    if (bus.reg_write_m && bus.rd_m != 0 && bus.rd_m == rs) return 2'd2;
    if (bus.reg_write_w && bus.rd_w != 0 && bus.rd_w == rs) return 2'd1;
    return 2'd0;
  endfunction

  task automatic check_e(input string pfx);
    check_eq({pfx, ".valid_e"},     bus.valid_e,     m_e.valid);
    check_eq({pfx, ".pc_e"},        bus.pc_e,        m_e.pc);
    check_eq({pfx, ".rs1_e"},       bus.rs1_e,       m_e.rs1);
    check_eq({pfx, ".rs2_e"},       bus.rs2_e,       m_e.rs2);
    check_eq({pfx, ".rd_e"},        bus.rd_e,        m_e.rd);
    check_eq({pfx, ".rd1_e"},       bus.rd1_e,       m_e.rd1);
    check_eq({pfx, ".rd2_e"},       bus.rd2_e,       m_e.rd2);
    check_eq({pfx, ".imm_e"},       bus.imm_e,       m_e.imm);
    check_eq({pfx, ".ctrl_e"},      bus.ctrl_e,      m_e.ctrl);
    check_eq({pfx, ".reg_write_e"}, bus.reg_write_e, m_e.wr);
    check_eq({pfx, ".mem_read_e"},  bus.mem_read_e,  m_e.ld);
    check_eq({pfx, ".bubble_cnt"},  bus.bubble_cnt,  m_cnt);
  endtask

  // One clock: combinational checks at negedge, model step at posedge, state checks after.
  task automatic cycle();
    bit lu;
    @(negedge clk);
    lu = load_use();
    check_eq("stall_d", bus.stall_d, !bus.flush_e && (bus.hold_e || lu));
    check_eq("fwd_a", bus.fwd_a, want_fwd(m_e.rs1));
    check_eq("fwd_b", bus.fwd_b, want_fwd(m_e.rs2));
    @(posedge clk);
    if (bus.flush_e) begin
      m_e = bubble();
    end else if (bus.hold_e) begin
      m_e = m_e;
    end else if (lu) begin
      m_e = bubble();
      if (m_cnt < CMAX) m_cnt++;
    end else begin
      m_e.valid = bus.valid_d;  m_e.pc = bus.pc_d;
      m_e.rs1 = bus.rs1_d; m_e.rs2 = bus.rs2_d; m_e.rd = bus.rd_d;
      m_e.rd1 = bus.rd1_d; m_e.rd2 = bus.rd2_d; m_e.imm = bus.imm_d;
      m_e.ctrl = bus.ctrl_d;
      m_e.wr = bus.valid_d && bus.reg_write_d;
      m_e.ld = bus.valid_d && bus.mem_read_d;
    end
    #1;
    check_e("e");
  endtask

  task automatic drive(input bit v, input bit [31:0] pc, input bit [4:0] rs1,
                       input bit [4:0] rs2, input bit [4:0] rd, input bit ld, input bit wr);
    bus.valid_d = v; bus.pc_d = pc; bus.rs1_d = rs1; bus.rs2_d = rs2; bus.rd_d = rd;
    bus.mem_read_d = ld; bus.reg_write_d = wr;
    bus.rd1_d = $urandom; bus.rd2_d = $urandom; bus.imm_d = $urandom;
    bus.ctrl_d = 8'($urandom);
    bus.flush_e = 1'b0; bus.hold_e = 1'b0;
    bus.rd_m = 5'd0; bus.reg_write_m = 1'b0; bus.rd_w = 5'd0; bus.reg_write_w = 1'b0;
  endtask

  task automatic rand_inputs();
    drive($urandom_range(99) < 85, $urandom, 5'($urandom_range(3)), 5'($urandom_range(3)),
          5'($urandom_range(3)), $urandom_range(99) < 40, $urandom_range(1) == 1);
    bus.flush_e     = $urandom_range(99) < 10;
    bus.hold_e      = $urandom_range(99) < 15;
    bus.rd_m        = 5'($urandom_range(3));
    bus.reg_write_m = $urandom_range(1) == 1;
    bus.rd_w        = 5'($urandom_range(3));
    bus.reg_write_w = $urandom_range(1) == 1;
  endtask

  initial begin
    m_e = bubble();
    m_cnt = 0;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    bus.hold_e = 1'b1;
    #2;
    check_e("reset");
    check_eq("reset.stall_d", bus.stall_d, 1'b1);
    check_eq("reset.fwd_a", bus.fwd_a, 2'b00);
    @(posedge clk);
    #1 rst = 1'b1;

    // addi x1 then addi x2 depending on x1
    drive(1'b1, 32'h0, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1);
    cycle();
    check_eq("addi1.pc_e", bus.pc_e, 32'h0);
    drive(1'b1, 32'h4, 5'd1, 5'd0, 5'd2, 1'b0, 1'b1);
    cycle();
    check_eq("addi2.rs1_e", bus.rs1_e, 5'd1);
    drive(1'b0, 32'h8, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    bus.rd_m = 5'd1; bus.reg_write_m = 1'b1;
    #1 check_eq("addi2.fwd_a", bus.fwd_a, 2'b10);
    cycle();

    // lw x5 followed by add x6,x5,x7
    drive(1'b1, 32'h10, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1);
    cycle();
    drive(1'b1, 32'h14, 5'd5, 5'd7, 5'd6, 1'b0, 1'b1);
    #1 check_eq("lu.stall_d", bus.stall_d, 1'b1);
    cycle();
    check_eq("lu.bubble_valid", bus.valid_e, 1'b0);
    check_eq("lu.bubble_cnt", bus.bubble_cnt, 4'd1);
    check_eq("lu.stall_after", bus.stall_d, 1'b0);
    cycle();
    check_eq("lu.add_pc", bus.pc_e, 32'h14);
    bus.valid_d = 1'b0; bus.rd_w = 5'd5; bus.reg_write_w = 1'b1;
    #1 check_eq("lu.fwd_a_wb", bus.fwd_a, 2'b01);
    cycle();

    // lw x0: no hazard
    drive(1'b1, 32'h20, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
    cycle();
    drive(1'b1, 32'h24, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1);
    #1 check_eq("x0.stall_d", bus.stall_d, 1'b0);
    cycle();
    check_eq("x0.cnt", bus.bubble_cnt, 4'd1);

    // flush together with load-use, then flush together with hold
    drive(1'b1, 32'h30, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
    cycle();
    drive(1'b1, 32'h34, 5'd5, 5'd0, 5'd6, 1'b0, 1'b1);
    bus.flush_e = 1'b1;
    #1 check_eq("flush_lu.stall_d", bus.stall_d, 1'b0);
    cycle();
    check_eq("flush_lu.cnt", bus.bubble_cnt, 4'd1);
    drive(1'b1, 32'h38, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    cycle();
    bus.flush_e = 1'b1; bus.hold_e = 1'b1;
    cycle();
    check_eq("flush_hold.valid_e", bus.valid_e, 1'b0);

    // hold for three cycles with changing decode inputs
    drive(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h44 + 32'(4 * i), 5'd4, 5'd5, 5'd6, 1'b0, 1'b1);
      bus.hold_e = 1'b1;
      cycle();
      check_eq("hold.pc_frozen", bus.pc_e, 32'h40);
    end
    drive(1'b1, 32'h60, 5'd4, 5'd5, 5'd6, 1'b0, 1'b1);
    cycle();
    check_eq("hold.release_pc", bus.pc_e, 32'h60);

    // saturation: 17 more load-use bubbles
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
      cycle();
      drive(1'b1, 32'h104, 5'd3, 5'd9, 5'd10, 1'b0, 1'b1);
      cycle();
    end
    check_eq("sat.cnt", bus.bubble_cnt, 4'hF);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    // asynchronous reset between edges
    drive(1'b1, 32'h200, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    cycle();
    #2 rst = 1'b0;
    bus.hold_e = 1'b1;
    m_e = bubble();
    m_cnt = 0;
    #1;
    check_e("async_rst");
    check_eq("async_rst.stall_d", bus.stall_d, 1'b1);
    check_eq("async_rst.fwd_b", bus.fwd_b, 2'b00);
    rst = 1'b1;
    bus.hold_e = 1'b0;
    for (int i = 0; i < 100; i++) begin
      rand_inputs();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
